// File: rtl/axis_buf_pkg.sv
// Shared helpers for the AXI4-Stream packet FIFO: pointer sizing and the
// layout of a stored beat record {TLAST, TSTRB, TDATA}.
package axis_buf_pkg;

    localparam int DATA_LSB = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int x = value - 1; x > 0; x = x >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int beat_w(input int tdata_w);
        return tdata_w + tdata_w / 8 + 1;
    endfunction

    function automatic int strb_lsb(input int tdata_w);
        return tdata_w;
    endfunction

    function automatic int last_bit(input int tdata_w);
        return tdata_w + tdata_w / 8;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage for the packet FIFO: one synchronous write port and one
// combinational read port so the head entry drives the master port directly.
module axis_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 37,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_slave_pkt_fifo.sv
// AXI4-Stream slave-to-master packet FIFO with occupancy and packet tracking.
// Define AXIS_STORE_FWD_EN to hold output until a complete packet is stored.
module axis_slave_pkt_fifo
    import axis_buf_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    localparam int STRB_W = C_S_AXIS_TDATA_WIDTH / 8,
    localparam int PTR_W  = clog2(FIFO_DEPTH)
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESETN,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [STRB_W-1:0]               S_AXIS_TSTRB,
    input  logic                            S_AXIS_TLAST,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [STRB_W-1:0]               M_AXIS_TSTRB,
    output logic                            M_AXIS_TLAST,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic [PTR_W:0]                  fill_level,
    output logic [PTR_W:0]                  pkt_count,
    output logic                            pkt_done
);

    localparam int BEAT_W   = beat_w(C_S_AXIS_TDATA_WIDTH);
    localparam int STRB_LSB = strb_lsb(C_S_AXIS_TDATA_WIDTH);
    localparam int LAST_BIT = last_bit(C_S_AXIS_TDATA_WIDTH);
    localparam logic [PTR_W:0] ONE = 1;

    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [PTR_W:0]    r_pkt_count;
    logic              r_pkt_done;
    logic              r_rdy_en;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [BEAT_W-1:0] w_wbeat;
    logic [BEAT_W-1:0] w_rbeat;

    // Wrap bit distinguishes full from empty when the low bits coincide.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

    assign S_AXIS_TREADY = r_rdy_en && !w_full;
    assign w_push        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_pop         = M_AXIS_TVALID && M_AXIS_TREADY;
    assign w_wbeat       = {S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TDATA};

    axis_fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (S_AXIS_ACLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[PTR_W-1:0]),
        .i_wdata (w_wbeat),
        .i_raddr (r_rd_ptr[PTR_W-1:0]),
        .o_rdata (w_rbeat)
    );

    assign M_AXIS_TDATA = w_rbeat[DATA_LSB +: C_S_AXIS_TDATA_WIDTH];
    assign M_AXIS_TSTRB = w_rbeat[STRB_LSB +: STRB_W];
    assign M_AXIS_TLAST = w_rbeat[LAST_BIT];

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_pkt_count <= '0;
            r_pkt_done  <= 1'b0;
            r_rdy_en    <= 1'b0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_pkt_done <= w_push && S_AXIS_TLAST;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE;
            end
            case ({w_push && S_AXIS_TLAST, w_pop && M_AXIS_TLAST})
                2'b10:   r_pkt_count <= r_pkt_count + ONE;
                2'b01:   r_pkt_count <= r_pkt_count - ONE;
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end

`ifdef AXIS_STORE_FWD_EN
    logic r_cut_thru;

    // A full FIFO without any TLAST would never drain, so fall back to
    // cut-through until the oversized packet's TLAST has left.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            r_cut_thru <= 1'b0;
        end else if (w_pop && M_AXIS_TLAST) begin
            r_cut_thru <= 1'b0;
        end else if (w_full && (r_pkt_count == '0)) begin
            r_cut_thru <= 1'b1;
        end
    end

    assign M_AXIS_TVALID = !w_empty && ((r_pkt_count != '0) || w_full || r_cut_thru);
`else
    assign M_AXIS_TVALID = !w_empty;
`endif

    assign fill_level = r_wr_ptr - r_rd_ptr;
    assign pkt_count  = r_pkt_count;
    assign pkt_done   = r_pkt_done;

endmodule

// File: tb/tb_axis_slave_pkt_fifo.sv
// Directed self-checking bench for axis_slave_pkt_fifo (DATA 32, DEPTH 16).
// Store-and-forward expectations are selected by AXIS_STORE_FWD_EN.
module tb_axis_slave_pkt_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [4:0]  fill;
    logic [4:0]  pcnt;
    logic        pdone;

    int nchk = 0;
    int nbad = 0;

    axis_slave_pkt_fifo #(
        .C_S_AXIS_TDATA_WIDTH (32),
        .FIFO_DEPTH           (16)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TSTRB   (s_tstrb),
        .S_AXIS_TLAST   (s_tlast),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TREADY  (s_tready),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TSTRB   (m_tstrb),
        .M_AXIS_TLAST   (m_tlast),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TREADY  (m_tready),
        .fill_level     (fill),
        .pkt_count      (pcnt),
        .pkt_done       (pdone)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD_0000;
        s_tstrb  = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nchk++;
        if (s_tready !== 1'b0 || fill !== 5'd0 || m_tvalid !== 1'b0 || pcnt !== 5'd0 || pdone !== 1'b0) begin
            nbad++;
            $display("FAIL reset_release: tready=%b fill=%0d tvalid=%b pcnt=%0d pdone=%b want 0 0 0 0 0",
                     s_tready, fill, m_tvalid, pcnt, pdone);
        end
        tick();
        nchk++;
        if (s_tready !== 1'b1 || fill !== 5'd0) begin
            nbad++;
            $display("FAIL reset_first_edge: tready=%b fill=%0d want tready=1 fill=0", s_tready, fill);
        end
        s_tvalid = 1'b0;
        tick();
        nchk++;
        if (s_tready !== 1'b1 || fill !== 5'd0 || m_tvalid !== 1'b0) begin
            nbad++;
            $display("FAIL reset_second_edge: tready=%b fill=%0d tvalid=%b want 1 0 0", s_tready, fill, m_tvalid);
        end
        $display("test_reset complete");
    endtask

    task automatic test_fill_drain;
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(i);
            s_tstrb  = 4'hF;
            s_tlast  = (i == 15);
            #1;
            nchk++;
            if (s_tready !== 1'b1) begin
                nbad++;
                $display("FAIL fill_tready beat %0d: got %b want 1", i, s_tready);
            end
            tick();
        end
        s_tlast = 1'b0;
        nchk++;
        if (s_tready !== 1'b0 || fill !== 5'd16 || pcnt !== 5'd1 || m_tvalid !== 1'b1) begin
            nbad++;
            $display("FAIL full_state: tready=%b fill=%0d pcnt=%0d tvalid=%b want 0 16 1 1",
                     s_tready, fill, pcnt, m_tvalid);
        end
        // Push attempt while full and popping: must be refused.
        s_tvalid = 1'b1;
        s_tdata  = 32'h0000_0BAD;
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            nchk++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'(i) || m_tlast !== (i == 15)) begin
                nbad++;
                $display("FAIL drain beat %0d: tvalid=%b data=%h last=%b want 1 %h %b",
                         i, m_tvalid, m_tdata, m_tlast, 32'(i), (i == 15));
            end
            if (i == 0) begin
                nchk++;
                if (s_tready !== 1'b0) begin
                    nbad++;
                    $display("FAIL full_pop_tready: got %b want 0", s_tready);
                end
            end
            tick();
            if (i == 0) begin
                s_tvalid = 1'b0;
                nchk++;
                if (fill !== 5'd15) begin
                    nbad++;
                    $display("FAIL full_pop_fill: got %0d want 15", fill);
                end
            end
        end
        m_tready = 1'b0;
        nchk++;
        if (fill !== 5'd0 || m_tvalid !== 1'b0 || pcnt !== 5'd0) begin
            nbad++;
            $display("FAIL drained: fill=%0d tvalid=%b pcnt=%0d want 0 0 0", fill, m_tvalid, pcnt);
        end
        $display("test_fill_drain complete");
    endtask

    task automatic test_stream_wrap;
        int exp_wr;
        int exp_rd;
        m_tready = 1'b0;
        s_tlast  = 1'b1;
        s_tstrb  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hA000_0000 + 32'(k);
            tick();
        end
        exp_wr = 5;
        exp_rd = 0;
        m_tready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            s_tdata = 32'hA000_0000 + 32'(exp_wr);
            #1;
            nchk++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'hA000_0000 + 32'(exp_rd) || fill !== 5'd5) begin
                nbad++;
                $display("FAIL stream cycle %0d: tvalid=%b data=%h fill=%0d want 1 %h 5",
                         c, m_tvalid, m_tdata, fill, 32'hA000_0000 + 32'(exp_rd));
            end
            tick();
            exp_wr++;
            exp_rd++;
        end
        s_tvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            nchk++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'hA000_0000 + 32'(exp_rd)) begin
                nbad++;
                $display("FAIL stream_tail %0d: tvalid=%b data=%h want 1 %h",
                         k, m_tvalid, m_tdata, 32'hA000_0000 + 32'(exp_rd));
            end
            tick();
            exp_rd++;
        end
        m_tready = 1'b0;
        s_tlast  = 1'b0;
        nchk++;
        if (fill !== 5'd0 || pcnt !== 5'd0) begin
            nbad++;
            $display("FAIL stream_end: fill=%0d pcnt=%0d want 0 0", fill, pcnt);
        end
        $display("test_stream_wrap complete");
    endtask

    task automatic test_packet;
        logic [3:0] strbs [3];
        logic       exp_v;
        logic [4:0] exp_pc;
        strbs[0] = 4'h1;
        strbs[1] = 4'h3;
        strbs[2] = 4'hF;
        m_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hC000_0000 + 32'(k);
            s_tstrb  = strbs[k];
            s_tlast  = (k == 2);
            tick();
`ifdef AXIS_STORE_FWD_EN
            exp_v = (k == 2);
`else
            exp_v = 1'b1;
`endif
            exp_pc = (k == 2) ? 5'd1 : 5'd0;
            nchk++;
            if (pdone !== (k == 2) || pcnt !== exp_pc || m_tvalid !== exp_v) begin
                nbad++;
                $display("FAIL pkt_push beat %0d: pdone=%b pcnt=%0d tvalid=%b want %b %0d %b",
                         k, pdone, pcnt, m_tvalid, (k == 2), exp_pc, exp_v);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        nchk++;
        if (pdone !== 1'b0 || pcnt !== 5'd1 || fill !== 5'd3) begin
            nbad++;
            $display("FAIL pkt_hold: pdone=%b pcnt=%0d fill=%0d want 0 1 3", pdone, pcnt, fill);
        end
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            nchk++;
            if (m_tdata !== 32'hC000_0000 + 32'(k) || m_tstrb !== strbs[k] || m_tlast !== (k == 2)) begin
                nbad++;
                $display("FAIL pkt_pop beat %0d: data=%h strb=%h last=%b want %h %h %b",
                         k, m_tdata, m_tstrb, m_tlast, 32'hC000_0000 + 32'(k), strbs[k], (k == 2));
            end
            tick();
            exp_pc = (k == 2) ? 5'd0 : 5'd1;
            nchk++;
            if (pcnt !== exp_pc) begin
                nbad++;
                $display("FAIL pkt_count after pop %0d: got %0d want %0d", k, pcnt, exp_pc);
            end
        end
        m_tready = 1'b0;
        nchk++;
        if (fill !== 5'd0 || m_tvalid !== 1'b0) begin
            nbad++;
            $display("FAIL pkt_end: fill=%0d tvalid=%b want 0 0", fill, m_tvalid);
        end
        $display("test_packet complete");
    endtask

    task automatic test_back_to_back;
        int  nsent;
        int  nrecv;
        int  cyc;
        bit  first_seen;
        bit  push;
        bit  pop;
        nsent = 0;
        nrecv = 0;
        cyc   = 0;
        first_seen = 1'b0;
        m_tready = 1'b1;
        s_tstrb  = 4'hF;
        while (nrecv < 20 && cyc < 400) begin
            s_tvalid = (nsent < 20);
            s_tdata  = 32'hD000_0000 + 32'(nsent);
            s_tlast  = (nsent == 19);
            #1;
            push = s_tvalid && s_tready;
            pop  = m_tvalid && m_tready;
            if (pop) begin
                nchk++;
                if (m_tdata !== 32'hD000_0000 + 32'(nrecv) || m_tlast !== (nrecv == 19)) begin
                    nbad++;
                    $display("FAIL b2b beat %0d: data=%h last=%b want %h %b",
                             nrecv, m_tdata, m_tlast, 32'hD000_0000 + 32'(nrecv), (nrecv == 19));
                end
`ifdef AXIS_STORE_FWD_EN
                if (!first_seen) begin
                    nchk++;
                    if (fill !== 5'd16) begin
                        nbad++;
                        $display("FAIL b2b_start_fill: got %0d want 16", fill);
                    end
                end
`endif
                first_seen = 1'b1;
            end
            @(posedge clk);
            #1;
            if (push) nsent++;
            if (pop) nrecv++;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        nchk++;
        if (nrecv !== 20 || fill !== 5'd0 || pcnt !== 5'd0 || m_tvalid !== 1'b0) begin
            nbad++;
            $display("FAIL b2b_done: recv=%0d fill=%0d pcnt=%0d tvalid=%b want 20 0 0 0",
                     nrecv, fill, pcnt, m_tvalid);
        end
        $display("test_back_to_back complete: %0d beats in %0d cycles", nrecv, cyc);
    endtask

    task automatic test_mid_reset;
        m_tready = 1'b0;
        s_tstrb  = 4'hF;
        for (int k = 0; k < 7; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hE000_0000 + 32'(k);
            s_tlast  = (k == 6);
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        nchk++;
        if (fill !== 5'd7 || pcnt !== 5'd1 || m_tvalid !== 1'b1) begin
            nbad++;
            $display("FAIL pre_reset: fill=%0d pcnt=%0d tvalid=%b want 7 1 1", fill, pcnt, m_tvalid);
        end
        rst_n = 1'b0;
        #1;
        nchk++;
        if (m_tvalid !== 1'b0 || fill !== 5'd0 || pcnt !== 5'd0 || s_tready !== 1'b0) begin
            nbad++;
            $display("FAIL async_reset: tvalid=%b fill=%0d pcnt=%0d tready=%b want 0 0 0 0",
                     m_tvalid, fill, pcnt, s_tready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        nchk++;
        if (m_tvalid !== 1'b0 || fill !== 5'd0 || s_tready !== 1'b1) begin
            nbad++;
            $display("FAIL post_reset: tvalid=%b fill=%0d tready=%b want 0 0 1", m_tvalid, fill, s_tready);
        end
        s_tvalid = 1'b1;
        s_tdata  = 32'h0000_0055;
        s_tlast  = 1'b1;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        nchk++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h0000_0055 || fill !== 5'd1) begin
            nbad++;
            $display("FAIL fresh_beat: tvalid=%b data=%h fill=%0d want 1 00000055 1", m_tvalid, m_tdata, fill);
        end
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        nchk++;
        if (fill !== 5'd0 || m_tvalid !== 1'b0) begin
            nbad++;
            $display("FAIL fresh_drain: fill=%0d tvalid=%b want 0 0", fill, m_tvalid);
        end
        $display("test_mid_reset complete");
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream_wrap();
        test_packet();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
